// File: rtl/key_event_if.sv
// Purpose: bundles the PS/2 byte input strobe and the event/state outputs
//          of key_event_ctl into a single interface.
// Signals:
//   rx_data      - received PS/2 byte, valid while rx_done_tick=1
//   rx_done_tick - one-cycle strobe, one byte received
//   evt_ready    - consumer accepts the head event
//   evt_valid    - event FIFO non-empty
//   evt_key      - key index of the head event
//   evt_press    - 1=press, 0=release for the head event
//   key_state    - current held state, one bit per key index
//   overflow     - sticky flag, an event was dropped
// Modports: master = byte source / event consumer, slave = key_event_ctl.
interface key_event_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic       evt_press;
  logic [5:0] key_state;
  logic       overflow;

  modport master (
    output rx_data, rx_done_tick, evt_ready,
    input  evt_valid, evt_key, evt_press, key_state, overflow
  );

  modport slave (
    input  rx_data, rx_done_tick, evt_ready,
    output evt_valid, evt_key, evt_press, key_state, overflow
  );
endinterface

// File: rtl/key_event_ctl.sv
// Purpose: parses PS/2 set-2 scancode sequences for six game keys
//          (W, A, D, Up, Left, Right), tracks their held state and queues
//          press/release events in a first-word-fall-through FIFO.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - key_event_if.slave (byte input, event FIFO output, key state,
//         sticky overflow flag)
module key_event_ctl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic            clk,
  input  logic            rst,
  key_event_if.slave      bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_key_state;
  logic             r_overflow;
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [3:0]       r_mem [FIFO_DEPTH];

  logic [1:0] w_next_state;
  logic       w_final;
  logic       w_make;
  logic       w_ext;
  logic [3:0] w_map;
  logic       w_hit;
  logic [2:0] w_idx;
  logic       w_change;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push_ok;
  logic [3:0] w_head;

  // Returns {hit, index}; extended and non-extended codes are separate maps.
  function automatic logic [3:0] map_key(input logic [7:0] b, input logic ext);
    logic [3:0] r;
    r = 4'b0000;
    if (!ext) begin
      case (b)
        8'h1D:   r = 4'b1000;
        8'h1C:   r = 4'b1001;
        8'h23:   r = 4'b1010;
        default: r = 4'b0000;
      endcase
    end else begin
      case (b)
        8'h75:   r = 4'b1011;
        8'h6B:   r = 4'b1100;
        8'h74:   r = 4'b1101;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  // Parser: a received byte always has priority over the timeout.
  always_comb begin
    w_next_state = r_state;
    w_final      = 1'b0;
    w_make       = 1'b0;
    w_ext        = 1'b0;
    if (bus.rx_done_tick) begin
      case (r_state)
        S_IDLE: begin
          if (bus.rx_data == B_EXT)      w_next_state = S_EXT;
          else if (bus.rx_data == B_BRK) w_next_state = S_BRK;
          else begin
            w_final = 1'b1;
            w_make  = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.rx_data == B_BRK)      w_next_state = S_EXT_BRK;
          else if (bus.rx_data == B_EXT) w_next_state = S_EXT;
          else begin
            w_final      = 1'b1;
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        S_BRK: begin
          // E0/F0 here is a protocol error: abandon without an update
          w_next_state = S_IDLE;
          w_final      = (bus.rx_data != B_EXT) && (bus.rx_data != B_BRK);
        end
        default: begin
          w_next_state = S_IDLE;
          w_final      = (bus.rx_data != B_EXT) && (bus.rx_data != B_BRK);
          w_ext        = 1'b1;
        end
      endcase
    end else if ((r_state != S_IDLE) && (r_cnt == CNT_LAST)) begin
      w_next_state = S_IDLE;
    end
  end

  assign w_map    = map_key(bus.rx_data, w_ext);
  assign w_hit    = w_final && w_map[3];
  assign w_idx    = w_map[2:0];
  // Only real state transitions become events; repeats are filtered here.
  assign w_change = w_hit && (r_key_state[w_idx] != w_make);

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop     = !w_empty && bus.evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = w_change && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_key_state <= '0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state <= w_next_state;
      if (bus.rx_done_tick || (r_state == S_IDLE) || (r_cnt == CNT_LAST))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_hit)
        r_key_state[w_idx] <= w_make;
      if (w_change && !w_push_ok)
        r_overflow <= 1'b1;
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {w_idx, w_make};
  end

  assign bus.evt_valid = !w_empty;
  assign bus.evt_key   = w_empty ? 3'd0 : w_head[3:1];
  assign bus.evt_press = w_empty ? 1'b0 : w_head[0];
  assign bus.key_state = r_key_state;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_ctl.sv
module tb_key_event_ctl;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_event_if bus ();

  key_event_ctl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
  endtask

  task automatic head(input string tag, input logic [2:0] k, input logic p);
    chk({tag, "_valid"}, bus.evt_valid, 1'b1);
    chk({tag, "_key"},   bus.evt_key,   k);
    chk({tag, "_press"}, bus.evt_press, p);
  endtask

  // Checks the head (after one extra held cycle) and pops it.
  task automatic pop_chk(input string tag, input logic [2:0] k, input logic p);
    @(negedge clk);
    head(tag, k, p);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.evt_valid, 1'b0);
    chk({tag, "_key"},   bus.evt_key,   3'd0);
    chk({tag, "_press"}, bus.evt_press, 1'b0);
    chk({tag, "_state"}, bus.key_state, 6'h00);
    chk({tag, "_ovf"},   bus.overflow,  1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.evt_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // W press then release, consumer always ready
    bus.evt_ready = 1'b1;
    send(8'h1D);
    head("w_make", 3'd0, 1'b1);
    chk("w_make_state", bus.key_state, 6'h01);
    send(8'hF0);
    chk("w_f0_empty", bus.evt_valid, 1'b0);
    send(8'h1D);
    head("w_break", 3'd0, 1'b0);
    chk("w_break_state", bus.key_state, 6'h00);
    @(negedge clk);
    bus.evt_ready = 1'b0;
    chk("w_drained", bus.evt_valid, 1'b0);

    // Left with typematic repeat, then release
    send(8'hE0); send(8'h6B);
    chk("left_state", bus.key_state, 6'h10);
    send(8'hE0); send(8'h6B);
    chk("left_rep_state", bus.key_state, 6'h10);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("left_rel_state", bus.key_state, 6'h00);
    pop_chk("left_ev0", 3'd4, 1'b1);
    pop_chk("left_ev1", 3'd4, 1'b0);
    chk("left_only_two", bus.evt_valid, 1'b0);
    send(8'h1C);
    chk("a_state", bus.key_state, 6'h02);
    pop_chk("a_make", 3'd1, 1'b1);
    send(8'hF0); send(8'h1C);
    pop_chk("a_break", 3'd1, 1'b0);

    // E0 followed by a gap just short of the timeout keeps the prefix
    send(8'hE0);
    repeat (TMO - 4) @(negedge clk);
    send(8'h75);
    chk("up_state", bus.key_state, 6'h08);
    pop_chk("up_make", 3'd3, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    pop_chk("up_break", 3'd3, 1'b0);

    // E0 followed by a gap past the timeout abandons the prefix
    send(8'hE0);
    repeat (TMO + 2) @(negedge clk);
    send(8'h75);
    chk("tmo_state", bus.key_state, 6'h00);
    chk("tmo_no_evt", bus.evt_valid, 1'b0);

    // Fill the FIFO with the consumer stalled, overflow on the fifth
    send(8'h1D);
    send(8'h1C);
    send(8'h23);
    send(8'hF0); send(8'h1D);
    chk("full_no_ovf", bus.overflow, 1'b0);
    send(8'hF0); send(8'h1C);
    chk("ovf_set", bus.overflow, 1'b1);
    chk("ovf_state", bus.key_state, 6'h04);
    head("ovf_head", 3'd0, 1'b1);
    // Push and pop on the same edge while full
    send(8'hF0);
    @(negedge clk);
    bus.rx_data      = 8'h23;
    bus.rx_done_tick = 1'b1;
    bus.evt_ready    = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.evt_ready    = 1'b0;
    chk("pp_state", bus.key_state, 6'h00);
    pop_chk("fifo0", 3'd1, 1'b1);
    pop_chk("fifo1", 3'd2, 1'b1);
    pop_chk("fifo2", 3'd0, 1'b0);
    pop_chk("fifo3", 3'd2, 1'b0);
    chk("fifo_empty", bus.evt_valid, 1'b0);
    chk("ovf_sticky", bus.overflow, 1'b1);

    // Protocol error: F0 E0 74 is discarded, then E0 74 parses normally
    send(8'hF0); send(8'hE0); send(8'h74);
    chk("perr_state", bus.key_state, 6'h00);
    chk("perr_no_evt", bus.evt_valid, 1'b0);
    send(8'hE0); send(8'h74);
    chk("right_state", bus.key_state, 6'h20);
    send(8'h1D);
    chk("two_held", bus.key_state, 6'h21);
    head("right_head", 3'd5, 1'b1);

    // Reset in the middle of a break sequence, asynchronously
    send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_rst");
    send(8'h23);
    chk("d_state", bus.key_state, 6'h04);
    head("d_make", 3'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
